// File: rtl/uart_word_fifo_pkg.sv
// Shared constants and types for the UART receive word path: baud-derived
// defaults, assembler state encoding and the byte-lane mapping helper.
package uart_word_fifo_pkg;

  localparam int unsigned CLK_FREQ       = 200_000_000;
  localparam int unsigned UART_BPS       = 115_200;
  localparam int unsigned CYCLES_PER_BIT = CLK_FREQ / UART_BPS;
  localparam int unsigned FRAME_BITS     = 10;
  // Two full frames of silence mid-word means the sender lost sync.
  localparam int unsigned DEF_TIMEOUT    = 2 * FRAME_BITS * CYCLES_PER_BIT;

  typedef enum logic [1:0] {
    ASM_IDLE   = 2'd0,
    ASM_FILL   = 2'd1,
    ASM_COMMIT = 2'd2
  } asm_state_e;

  // Maps an arrival index to a byte lane; the mapping is its own inverse.
  function automatic int unsigned lane_of(input int unsigned idx,
                                          input int unsigned bpw,
                                          input bit          big_endian);
    return big_endian ? (bpw - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/uart_word_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth.
// Head word is visible on rd_data_o whenever empty_o is low; zero otherwise.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A write into a full FIFO lands in the slot the same-cycle read frees.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_word_fifo.sv
// Packs UART receive bytes into words and queues them in a FWFT FIFO,
// with endianness select, inter-byte timeout resync, flush and overflow flag.
module uart_word_fifo
  import uart_word_fifo_pkg::*;
#(
  parameter  int unsigned BYTES_PER_WORD = 4,
  parameter  int unsigned FIFO_DEPTH     = 42,
  parameter  bit          BIG_ENDIAN     = 1'b0,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
  localparam int unsigned DATA_WIDTH     = 8 * BYTES_PER_WORD,
  localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  full,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  asm_state_e            state_q, state_d;
  logic                  rx_done_q;
  logic                  accept;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_nxt;
  logic [DATA_WIDTH-1:0] commit_q, commit_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  tmo_fire;
  logic                  timeout_err_q;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;

  // Edge detect keeps tracking rx_done through flush so a held level
  // cannot re-trigger once flush drops.
  always_ff @(posedge sys_clk) begin
    rx_done_q <= sys_rst ? 1'b0 : rx_done;
  end

  assign accept = rx_done && !rx_done_q;

  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
    localparam int unsigned IDX_FOR_LANE = lane_of(g, BYTES_PER_WORD, BIG_ENDIAN);
    logic hit;
    assign hit = accept && (byte_idx_q == IDX_W'(IDX_FOR_LANE));
    assign word_nxt[g*8 +: 8] = hit ? rx_data : word_q[g*8 +: 8];
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    commit_d   = commit_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_fire   = 1'b0;
    push       = 1'b0;

    if (state_q == ASM_COMMIT) begin
      push    = 1'b1;
      state_d = ASM_IDLE;
    end

    if (accept) begin
      tmo_cnt_d = '0;
      if (byte_idx_q == LAST_IDX) begin
        commit_d   = word_nxt;
        byte_idx_d = '0;
        state_d    = ASM_COMMIT;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        state_d    = ASM_FILL;
      end
    end else if ((TIMEOUT_CYCLES != 0) && (state_q == ASM_FILL) && (byte_idx_q != '0)) begin
      if (tmo_cnt_q == TMO_LAST) begin
        tmo_fire   = 1'b1;
        byte_idx_d = '0;
        tmo_cnt_d  = '0;
        state_d    = ASM_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  assign pop        = m_ready && !fifo_empty;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || flush) begin
      state_q       <= ASM_IDLE;
      byte_idx_q    <= '0;
      word_q        <= '0;
      commit_q      <= '0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_nxt;
      commit_q      <= commit_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= tmo_fire;
      overflow_q    <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .clr_i     (flush),
    .wr_en_i   (push),
    .wr_data_i (commit_q),
    .rd_en_i   (m_ready),
    .rd_data_o (m_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign m_valid     = !fifo_empty;
  assign full        = fifo_full;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_word_fifo.sv
// Directed bench for uart_word_fifo: little- and big-endian instances share stimulus.
module tb_uart_word_fifo;

  localparam int BPW   = 4;
  localparam int DEPTH = 42;
  localparam int TMO   = 200;
  localparam int DW    = 8 * BPW;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          flush   = 1'b0;
  logic          m_ready = 1'b0;

  logic          a_valid, a_full, a_ovf, a_tmo;
  logic [DW-1:0] a_data;
  logic [CW-1:0] a_count;
  logic          b_valid, b_full, b_ovf, b_tmo;
  logic [DW-1:0] b_data;
  logic [CW-1:0] b_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  uart_word_fifo #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b0),
                   .TIMEOUT_CYCLES(TMO)) dut_le (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_done(rx_done), .rx_data(rx_data),
    .flush(flush), .m_valid(a_valid), .m_ready(m_ready), .m_data(a_data),
    .fifo_count(a_count), .full(a_full), .overflow(a_ovf), .timeout_err(a_tmo));

  uart_word_fifo #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b1),
                   .TIMEOUT_CYCLES(TMO)) dut_be (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_done(rx_done), .rx_data(rx_data),
    .flush(flush), .m_valid(b_valid), .m_ready(m_ready), .m_data(b_data),
    .fifo_count(b_count), .full(b_full), .overflow(b_ovf), .timeout_err(b_tmo));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    tick();
  endtask

  // Last byte is accepted in T; pop (if requested) lands in T+1, the push cycle.
  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input bit pop);
    send_byte(b0, 1);
    send_byte(b1, 1);
    send_byte(b2, 1);
    rx_data = b3;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    m_ready = pop;
    tick();
    m_ready = 1'b0;
  endtask

  function automatic logic [31:0] wv(input int i);
    return {8'hC0, 8'hB0, 8'hA0, 8'(i)};
  endfunction

  task automatic send_idx(input int i, input bit pop);
    send_word(8'(i), 8'hA0, 8'hB0, 8'hC0, pop);
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    int pulses;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", a_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_full", a_full, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_tmo", a_tmo, 0);
    chk("rst_data", a_data, 0);
    sys_rst = 1'b0;
    tick();

    // 1: basic word and latency, both endians
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    rx_data = 8'h44;
    rx_done = 1'b1;
    tick();
    chk("lat_t1_valid", a_valid, 0);
    rx_done = 1'b0;
    tick();
    chk("lat_t2_valid", a_valid, 1);
    chk("le_word", a_data, 64'h44332211);
    chk("be_word", b_data, 64'h11223344);
    chk("one_count", a_count, 1);
    pop_one();
    chk("pop_empty_valid", a_valid, 0);
    chk("pop_empty_count", a_count, 0);

    // 2: level-held rx_done accepts one byte per rising edge
    send_byte(8'h01, 50);
    send_byte(8'h02, 50);
    send_byte(8'h03, 50);
    send_byte(8'h04, 50);
    tick();
    chk("level_count", a_count, 1);
    chk("level_word", a_data, 64'h04030201);
    pop_one();

    // 3: fill, overflow, in-order drain
    for (int i = 1; i <= DEPTH; i++) send_idx(i, 1'b0);
    chk("fill_full", a_full, 1);
    chk("fill_count", a_count, DEPTH);
    chk("fill_no_ovf", a_ovf, 0);
    send_idx(DEPTH + 1, 1'b0);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_count, DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("drain_%0d", i), a_data, wv(i));
      pop_one();
    end
    chk("drain_valid", a_valid, 0);
    chk("ovf_sticky", a_ovf, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovf", a_ovf, 0);

    // 4: push+pop while full, pointers wrap three times
    for (int i = 1; i <= DEPTH; i++) send_idx(i, 1'b0);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      chk($sformatf("pp_head_%0d", k), a_data, wv(k + 1));
      send_idx(DEPTH + 1 + k, 1'b1);
      chk($sformatf("pp_count_%0d", k), a_count, DEPTH);
    end
    chk("pp_no_ovf", a_ovf, 0);
    for (int i = 3 * DEPTH + 1; i <= 4 * DEPTH; i++) begin
      chk($sformatf("wrap_drain_%0d", i), a_data, wv(i));
      pop_one();
    end
    chk("wrap_drain_valid", a_valid, 0);

    // 5: timeout discards a partial word
    send_byte(8'h77, 1);
    send_byte(8'h88, 1);
    pulses = 0;
    repeat (TMO + 50) begin
      tick();
      if (a_tmo) pulses++;
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_no_push", a_count, 0);
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
    chk("tmo_resync_count", a_count, 1);
    chk("tmo_resync_le", a_data, 64'hDDCCBBAA);
    chk("tmo_resync_be", b_data, 64'hAABBCCDD);
    pop_one();

    // 6a: flush mid-word with words queued
    for (int i = 1; i <= 5; i++) send_idx(i, 1'b0);
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    chk("pre_flush_count", a_count, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", a_count, 0);
    chk("flush_ovf0", a_ovf, 0);
    chk("flush_valid", a_valid, 0);
    chk("flush_data", a_data, 0);
    send_word(8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
    chk("flush_clean_count", a_count, 1);
    chk("flush_clean_word", a_data, 64'h40302010);
    pop_one();

    // 6b: same with reset
    for (int i = 1; i <= 5; i++) send_idx(i, 1'b0);
    send_byte(8'h55, 1);
    send_byte(8'h66, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rst2_count", a_count, 0);
    chk("rst2_ovf", a_ovf, 0);
    chk("rst2_valid", a_valid, 0);
    send_word(8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
    chk("rst2_clean_count", a_count, 1);
    chk("rst2_clean_word", a_data, 64'h40302010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
